wb_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 5-bit register-destination mux feeding the register-file write port. It accepts write requests (register address plus data) from two sources, A and B. It picks one per cycle, drives the mux select `Sel` (0 = A, 1 = B), and issues a registered single-cycle write to the register file. Writes to register 0 are granted but suppressed.

---
 rtl/wb_port_arbiter_if.sv | 30 +++
 rtl/wb_port_arbiter.sv | 74 +++++++
 tb/tb_wb_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the A/B write requesters and the register-file write-port arbiter.
// The arbiter side uses modport slave; the requesters use modport master.
interface wb_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              ReqA;
  logic [ADDR_W-1:0] AddrA;
  logic [DATA_W-1:0] DataA;
  logic              GntA;
  logic              ReqB;
  logic [ADDR_W-1:0] AddrB;
  logic [DATA_W-1:0] DataB;
  logic              GntB;
  logic              Sel;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [7:0]        WrCount;

  modport slave (
    input  ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    output GntA, GntB, Sel, WrEn, WrAddr, WrData, WrCount
  );

  modport master (
    output ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    input  GntA, GntB, Sel, WrEn, WrAddr, WrData, WrCount
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter driving the register-file write port and destination mux select.
// Ties go to A (fixed priority) unless WBARB_ROUND_ROBIN_EN is defined, which alternates on LastGnt.
module wb_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic              Clk,
  input logic              Reset,
  wb_port_arbiter_if.slave bus
);
  logic              gnt_a_q, gnt_b_q;
  logic              sel_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [7:0]        wr_count_q;
  logic              last_gnt_q;  // 0 = A, 1 = B

  logic              eff_a, eff_b, grant, pick_b;
  logic              last_gnt_d, wr_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    // A requester granted this cycle still shows Req high; mask it out.
    eff_a = bus.ReqA & ~gnt_a_q;
    eff_b = bus.ReqB & ~gnt_b_q;
    grant = eff_a | eff_b;
`ifdef WBARB_ROUND_ROBIN_EN
    pick_b = eff_b & (~eff_a | ~last_gnt_q);
`else
    pick_b = eff_b & ~eff_a;
`endif
    addr_d     = pick_b ? bus.AddrB : bus.AddrA;
    data_d     = pick_b ? bus.DataB : bus.DataA;
    wr_en_d    = grant & (addr_d != '0);
    last_gnt_d = grant ? pick_b : last_gnt_q;
  end

  // Output register stage: everything the port sees comes straight from flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      sel_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= 8'd0;
      last_gnt_q <= 1'b1;
    end else begin
      gnt_a_q    <= grant & ~pick_b;
      gnt_b_q    <= grant & pick_b;
      wr_en_q    <= wr_en_d;
      last_gnt_q <= last_gnt_d;
      if (grant) begin
        sel_q     <= pick_b;
        wr_addr_q <= addr_d;
        wr_data_q <= data_d;
      end
      if (wr_en_d) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end

  assign bus.GntA    = gnt_a_q;
  assign bus.GntB    = gnt_b_q;
  assign bus.Sel     = sel_q;
  assign bus.WrEn    = wr_en_q;
  assign bus.WrAddr  = wr_addr_q;
  assign bus.WrData  = wr_data_q;
  assign bus.WrCount = wr_count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a grant-level reference model queues expected writes,
// and a negedge monitor pops and compares whenever a grant appears.
module tb_wb_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  wb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int                cyc;
    bit                b;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                wren;
    int                cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference state: who was granted last cycle, tie history, committed-write count, held outputs.
  bit                m_gnt_a  = 1'b0;
  bit                m_gnt_b  = 1'b0;
  bit                m_last_b = 1'b1;
  int                m_cnt    = 0;
  bit                m_sel    = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [DATA_W-1:0] m_data   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    bit   ea, eb, tie_b, win_b;
    exp_t e;
    if (Reset) begin
      m_gnt_a  = 1'b0;
      m_gnt_b  = 1'b0;
      m_last_b = 1'b1;
      m_cnt    = 0;
      m_sel    = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      expq.delete();
    end else begin
      cyc++;
      ea = bus.ReqA && !m_gnt_a;
      eb = bus.ReqB && !m_gnt_b;
`ifdef WBARB_ROUND_ROBIN_EN
      tie_b = !m_last_b;
`else
      tie_b = 1'b0;
`endif
      win_b   = (ea && eb) ? tie_b : eb;
      m_gnt_a = (ea || eb) && !win_b;
      m_gnt_b = (ea || eb) && win_b;
      if (ea || eb) begin
        e.cyc  = cyc;
        e.b    = win_b;
        e.addr = win_b ? bus.AddrB : bus.AddrA;
        e.data = win_b ? bus.DataB : bus.DataA;
        e.wren = (e.addr != 0);
        if (e.wren) m_cnt = (m_cnt + 1) % 256;
        e.cnt    = m_cnt;
        m_last_b = win_b;
        m_sel    = win_b;
        m_addr   = e.addr;
        m_data   = e.data;
        expq.push_back(e);
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (bus.GntA || bus.GntB) begin
        chk("gnt_pending", 64'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("gnt_cycle", cyc, e.cyc);
          chk("gnt_a", bus.GntA, !e.b);
          chk("gnt_b", bus.GntB, e.b);
          chk("sel", bus.Sel, e.b);
          chk("wr_addr", bus.WrAddr, e.addr);
          chk("wr_data", bus.WrData, e.data);
          chk("wr_en", bus.WrEn, e.wren);
          chk("wr_count", bus.WrCount, e.cnt);
        end
      end else begin
        chk("idle_pending", expq.size(), 0);
        chk("idle_wren", bus.WrEn, 0);
        chk("idle_count", bus.WrCount, m_cnt);
        chk("idle_sel", bus.Sel, m_sel);
        chk("idle_addr", bus.WrAddr, m_addr);
        chk("idle_data", bus.WrData, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    #2 Reset = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom % 6 == 0) return '0;
    return ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
  endfunction

  initial begin
    logic [7:0] cnt0;
    bus.ReqA = 1'b0; bus.AddrA = '0; bus.DataA = '0;
    bus.ReqB = 1'b0; bus.AddrB = '0; bus.DataB = '0;

    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_gnt_a", bus.GntA, 0);
    chk("rst_gnt_b", bus.GntB, 0);
    chk("rst_wren", bus.WrEn, 0);
    chk("rst_sel", bus.Sel, 0);
    chk("rst_addr", bus.WrAddr, 0);
    chk("rst_data", bus.WrData, 0);
    chk("rst_count", bus.WrCount, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    tick();

    // Single write from A
    bus.ReqA = 1'b1; bus.AddrA = 5'd2; bus.DataA = 32'h11;
    tick();
    chk("t1_gnt_a", bus.GntA, 1);
    chk("t1_sel", bus.Sel, 0);
    chk("t1_wren", bus.WrEn, 1);
    chk("t1_addr", bus.WrAddr, 2);
    chk("t1_data", bus.WrData, 32'h11);
    chk("t1_count", bus.WrCount, 1);
    bus.ReqA = 1'b0;
    tick();

    // Both held high from a fresh reset: A, B, A, B in either tie mode
    do_reset();
    tick();
    bus.ReqA = 1'b1; bus.AddrA = 5'd3; bus.DataA = $urandom;
    bus.ReqB = 1'b1; bus.AddrB = 5'd4; bus.DataB = $urandom;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_gnt_a", bus.GntA, (i % 2) == 0);
      chk("tie_gnt_b", bus.GntB, (i % 2) == 1);
    end
    bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    tick();

    // Register-0 write from B
    cnt0 = bus.WrCount;
    bus.ReqB = 1'b1; bus.AddrB = 5'd0; bus.DataB = 32'hFF;
    tick();
    chk("r0_gnt_b", bus.GntB, 1);
    chk("r0_sel", bus.Sel, 1);
    chk("r0_wren", bus.WrEn, 0);
    chk("r0_count", bus.WrCount, cnt0);
    bus.ReqB = 1'b0;
    tick();

    // A alone held for 6 cycles
    bus.ReqA = 1'b1; bus.AddrA = 5'd5; bus.DataA = $urandom;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_gnt_a", bus.GntA, (i % 2) == 0);
      chk("hold_wren", bus.WrEn, (i % 2) == 0);
    end
    bus.ReqA = 1'b0;
    tick();

    // Reset while GntB is high, both requests left pending
    bus.ReqB = 1'b1; bus.AddrB = 5'd7; bus.DataB = $urandom;
    tick();
    chk("mid_gnt_b", bus.GntB, 1);
    bus.ReqA = 1'b1; bus.AddrA = 5'd9; bus.DataA = $urandom;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_gnt_b", bus.GntB, 0);
    chk("mid_rst_wren", bus.WrEn, 0);
    chk("mid_rst_sel", bus.Sel, 0);
    chk("mid_rst_addr", bus.WrAddr, 0);
    chk("mid_rst_data", bus.WrData, 0);
    chk("mid_rst_count", bus.WrCount, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    tick();
    chk("post_rst_gnt_a", bus.GntA, 1);
    chk("post_rst_gnt_b", bus.GntB, 0);
    bus.ReqA = 1'b0;
    tick();
    chk("post_rst_gnt_b2", bus.GntB, 1);
    bus.ReqB = 1'b0;
    tick();

    // 256 back-to-back nonzero writes wrap the counter
    do_reset();
    bus.ReqA = 1'b1; bus.AddrA = 5'd3;
    bus.ReqB = 1'b1; bus.AddrB = 5'd4;
    for (int k = 1; k <= 256; k++) begin
      tick();
      bus.DataA = $urandom;
      bus.DataB = $urandom;
      if (k == 255) chk("wrap_255", bus.WrCount, 255);
    end
    chk("wrap_0", bus.WrCount, 0);
    bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    tick();

    // Random traffic obeying the requester rules, including abandoned requests
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!bus.ReqA) begin
        if ($urandom % 3 == 0) begin
          bus.ReqA = 1'b1; bus.AddrA = rand_addr(); bus.DataA = $urandom;
        end
      end else if (bus.GntA) begin
        if ($urandom % 2 == 0) begin
          bus.AddrA = rand_addr(); bus.DataA = $urandom;
        end else begin
          bus.ReqA = 1'b0;
        end
      end else if ($urandom % 16 == 0) begin
        bus.ReqA = 1'b0;
      end
      if (!bus.ReqB) begin
        if ($urandom % 3 == 0) begin
          bus.ReqB = 1'b1; bus.AddrB = rand_addr(); bus.DataB = $urandom;
        end
      end else if (bus.GntB) begin
        if ($urandom % 2 == 0) begin
          bus.AddrB = rand_addr(); bus.DataB = $urandom;
        end else begin
          bus.ReqB = 1'b0;
        end
      end else if ($urandom % 16 == 0) begin
        bus.ReqB = 1'b0;
      end
    end
    bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    repeat (3) tick();
    chk("final_queue", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
